// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage feeding the main decoder. Holds the
//               program counter and runs a req/ack handshake with instruction
//               memory. It latches the returned word and presents it to decode
//               until the datapath accepts it. It then advances the PC
//               sequentially or to a branch target, and counts retired
//               instructions.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, reset    rising-edge clock, asynchronous active-high reset
//   imemReq       fetch request (held until imemAck)
//   imemAddr      fetch address, always equal to pc
//   imemAck       imemRdata valid this cycle (sampled only while fetching)
//   imemRdata     instruction word from memory
//   instr, op     instruction register and its opcode field [6:0]
//   pc, pcPlus4   address of instr and pc + PC_STEP (link value)
//   instrValid    instr is valid and waiting for instrAccept
//   instrAccept   datapath consumes instr this cycle
//   pcSrc         redirect to pcTarget (sampled only on accept)
//   pcTarget      branch/jump target
//   fault         sticky misaligned-target flag
//   retired       accepted-instruction counter, wraps modulo 2^32
// ============================================================================
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imemReq,
  output logic [XLEN-1:0] imemAddr,
  input  logic            imemAck,
  input  logic [XLEN-1:0] imemRdata,
  output logic [XLEN-1:0] instr,
  output logic [6:0]      op,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcPlus4,
  output logic            instrValid,
  input  logic            instrAccept,
  input  logic            pcSrc,
  input  logic [XLEN-1:0] pcTarget,
  output logic            fault,
  output logic [31:0]     retired
);

  localparam logic [XLEN-1:0] c_STEP = XLEN'(PC_STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [31:0]     retired_q, retired_d;
  logic            fault_q, fault_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;

  // imemReq and instrValid are registered alongside the state so that they
  // are glitch-free and drop the moment reset asserts.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    fault_d   = fault_q;
    req_d     = req_q;
    valid_d   = valid_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        req_d   = 1'b1;
      end
      FETCH: begin
        if (imemAck) begin
          instr_d = imemRdata;
          req_d   = 1'b0;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (instrAccept) begin
          retired_d = retired_q + 32'd1;
          valid_d   = 1'b0;
          if (!pcSrc) begin
            pc_d    = pc_q + c_STEP;
            req_d   = 1'b1;
            state_d = FETCH;
          end else if (pcTarget[1:0] == 2'b00) begin
            pc_d    = pcTarget;
            req_d   = 1'b1;
            state_d = FETCH;
          end else begin
            // Misaligned target: keep pc pointing at the offending
            // instruction and stop fetching until reset.
            fault_d = 1'b1;
            state_d = HALT;
          end
        end
      end
      HALT: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
      fault_q   <= 1'b0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
    end
  end

  assign imemReq    = req_q;
  assign imemAddr   = pc_q;
  assign instr      = instr_q;
  assign op         = instr_q[6:0];
  assign pc         = pc_q;
  assign pcPlus4    = pc_q + c_STEP;
  assign instrValid = valid_q;
  assign fault      = fault_q;
  assign retired    = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A transaction-level model
//               tracks the expected pc, retired count and fault flag; the bench
//               plays the role of instruction memory and of the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck = 1'b0;
  logic [31:0] imemRdata = '0;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        instrValid;
  logic        instrAccept = 1'b0;
  logic        pcSrc = 1'b0;
  logic [31:0] pcTarget = '0;
  logic        fault;
  logic [31:0] retired;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic        m_fault;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk(clk), .reset(reset),
    .imemReq(imemReq), .imemAddr(imemAddr),
    .imemAck(imemAck), .imemRdata(imemRdata),
    .instr(instr), .op(op), .pc(pc), .pcPlus4(pcPlus4),
    .instrValid(instrValid), .instrAccept(instrAccept),
    .pcSrc(pcSrc), .pcTarget(pcTarget),
    .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    m_pc = 32'h0; m_ret = 32'h0; m_fault = 1'b0;
  endtask

  // Datapath accepts the held instruction; model follows the fetch rules.
  task automatic do_accept(input logic src, input logic [31:0] tgt);
    instrAccept = 1'b1; pcSrc = src; pcTarget = tgt;
    tick();
    instrAccept = 1'b0; pcSrc = 1'b0; pcTarget = $urandom;
    m_ret = m_ret + 32'd1;
    if (!src) m_pc = m_pc + 32'd4;
    else if (tgt[1:0] == 2'b00) m_pc = tgt;
    else m_fault = 1'b1;
  endtask

  // Memory side: wait (bounded) for a request, ack after lat cycles.
  task automatic do_fetch(input int lat, input logic [31:0] word,
                          output bit got, output logic [31:0] addr, output bit stable);
    int w = 0;
    got = 1'b0; stable = 1'b1; addr = 'x;
    while (!imemReq && w < 20) begin tick(); w++; end
    if (!imemReq) return;
    got = 1'b1;
    addr = imemAddr;
    for (int i = 0; i < lat; i++) begin
      tick();
      if (imemReq !== 1'b1 || imemAddr !== addr || instrValid !== 1'b0) stable = 1'b0;
    end
    imemAck = 1'b1; imemRdata = word;
    tick();
    imemAck = 1'b0; imemRdata = $urandom;
  endtask

  task automatic hard_reset;
    reset = 1'b1;
    #1;
    tick(); tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #2;
    n_tests++;
    if ({imemReq, instrValid, fault} !== 3'b000 || pc !== 32'h0 || instr !== 32'h0 || retired !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: req=%b valid=%b fault=%b pc=%h instr=%h retired=%h, want all zero",
               imemReq, instrValid, fault, pc, instr, retired);
    end
    tick();
    reset = 1'b0;
    model_reset();
    n_tests++;
    if (imemReq !== 1'b0) begin n_fail++; $display("FAIL idle_no_req: req=%b want 0", imemReq); end
    tick();
    n_tests++;
    if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin
      n_fail++; $display("FAIL first_req: req=%b addr=%h want 1/00000000", imemReq, imemAddr);
    end
  endtask

  task automatic test_zero_wait;
    bit got, stable; logic [31:0] a;
    for (int k = 0; k < 3; k++) begin
      do_fetch(0, 32'h00500093, got, a, stable);
      n_tests++;
      if (!got || a !== m_pc) begin
        n_fail++; $display("FAIL zw_addr[%0d]: got=%b addr=%h want %h", k, got, a, m_pc);
      end
      n_tests++;
      if (instrValid !== 1'b1 || op !== 7'h13 || imemReq !== 1'b0) begin
        n_fail++; $display("FAIL zw_hold[%0d]: valid=%b op=%h req=%b want 1/13/0", k, instrValid, op, imemReq);
      end
      do_accept(1'b0, 32'h0);
    end
    n_tests++;
    if (retired !== 32'd3) begin n_fail++; $display("FAIL zw_retired: got %0d want 3", retired); end
  endtask

  task automatic test_wait_states;
    bit got, stable; logic [31:0] a; logic [31:0] w = $urandom;
    do_fetch(3, w, got, a, stable);
    n_tests++;
    if (!got || !stable || a !== m_pc) begin
      n_fail++; $display("FAIL ws_req_stable: got=%b stable=%b addr=%h want 1/1/%h", got, stable, a, m_pc);
    end
    n_tests++;
    if (instrValid !== 1'b1 || instr !== w) begin
      n_fail++; $display("FAIL ws_instr: valid=%b instr=%h want 1/%h", instrValid, instr, w);
    end
    do_accept(1'b0, 32'h0);
  endtask

  task automatic test_hold_stall;
    bit got, stable, ok; logic [31:0] a; logic [31:0] w = $urandom;
    do_fetch(int'($urandom_range(0, 2)), w, got, a, stable);
    ok = got;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (instrValid !== 1'b1 || imemReq !== 1'b0 || instr !== w || pc !== m_pc || retired !== m_ret) ok = 1'b0;
    end
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL hold_stall: valid=%b req=%b instr=%h pc=%h ret=%0d want 1/0/%h/%h/%0d",
                         instrValid, imemReq, instr, pc, retired, w, m_pc, m_ret);
    end
    do_accept(1'b0, 32'h0);
  endtask

  task automatic test_branch;
    bit got, stable; logic [31:0] a;
    hard_reset();
    for (int k = 0; k < 2; k++) begin
      do_fetch(0, $urandom, got, a, stable);
      do_accept(1'b0, 32'h0);
    end
    do_fetch(1, 32'h0000006f, got, a, stable);
    n_tests++;
    if (pc !== 32'h8) begin n_fail++; $display("FAIL br_pc: pc=%h want 00000008", pc); end
    do_accept(1'b1, 32'h40);
    do_fetch(0, 32'h00000013, got, a, stable);
    n_tests++;
    if (!got || a !== 32'h40 || pcPlus4 !== 32'h44 || pc !== 32'h40) begin
      n_fail++; $display("FAIL br_target: addr=%h pc=%h pcPlus4=%h want 40/40/44", a, pc, pcPlus4);
    end
  endtask

  task automatic test_misaligned;
    bit ok = 1'b1; logic [31:0] r0 = retired;
    do_accept(1'b1, 32'h42);
    n_tests++;
    if (fault !== 1'b1 || pc !== 32'h40 || retired !== r0 + 32'd1) begin
      n_fail++; $display("FAIL mis_fault: fault=%b pc=%h ret=%0d want 1/40/%0d", fault, pc, retired, r0 + 32'd1);
    end
    for (int i = 0; i < 10; i++) begin
      imemAck = 1'b1;
      instrAccept = 1'b1;
      tick();
      if (imemReq !== 1'b0 || instrValid !== 1'b0 || fault !== 1'b1 || pc !== 32'h40) ok = 1'b0;
    end
    imemAck = 1'b0; instrAccept = 1'b0;
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL mis_halt: req=%b valid=%b fault=%b pc=%h want 0/0/1/40", imemReq, instrValid, fault, pc);
    end
  endtask

  task automatic test_reset_mid_fetch;
    bit got, stable; logic [31:0] a;
    hard_reset();
    tick();
    tick();
    imemAck = 1'b1; imemRdata = 32'hDEADBEEF;
    reset = 1'b1;
    #1;
    n_tests++;
    if (imemReq !== 1'b0 || instrValid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_fetch: req=%b valid=%b want 0/0", imemReq, instrValid);
    end
    tick();
    imemAck = 1'b0;
    reset = 1'b0;
    model_reset();
    n_tests++;
    if (instr !== 32'h0 || instrValid !== 1'b0) begin
      n_fail++; $display("FAIL rst_abandon: instr=%h valid=%b want 0/0", instr, instrValid);
    end
    do_fetch(0, 32'h00000033, got, a, stable);
    n_tests++;
    if (!got || a !== 32'h0 || op !== 7'h33) begin
      n_fail++; $display("FAIL rst_restart: got=%b addr=%h op=%h want 1/0/33", got, a, op);
    end
  endtask

  task automatic test_wrap;
    bit got, stable; logic [31:0] a;
    dut.retired_q = 32'hFFFF_FFFE;
    m_ret = 32'hFFFF_FFFE;
    do_accept(1'b0, 32'h0);
    n_tests++;
    if (retired !== m_ret) begin n_fail++; $display("FAIL wrap_pre: got %h want %h", retired, m_ret); end
    do_fetch(0, $urandom, got, a, stable);
    do_accept(1'b0, 32'h0);
    n_tests++;
    if (retired !== 32'h0) begin n_fail++; $display("FAIL wrap_zero: got %h want 00000000", retired); end
    dut.retired_q = 32'hFFFF_FFFD;
    reset = 1'b1;
    #1;
    n_tests++;
    if (retired !== 32'h0 || pc !== 32'h0) begin
      n_fail++; $display("FAIL wrap_reset: retired=%h pc=%h want 0/0", retired, pc);
    end
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_random;
    bit got, stable, ok; logic [31:0] a, w, tgt; logic src; int stall;
    hard_reset();
    for (int n = 0; n < 40; n++) begin
      w = $urandom;
      do_fetch(int'($urandom_range(0, 3)), w, got, a, stable);
      n_tests++;
      if (!got || !stable || a !== m_pc || instr !== w || op !== w[6:0] || pc !== m_pc ||
          pcPlus4 !== m_pc + 32'd4 || retired !== m_ret || instrValid !== 1'b1 || fault !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd_fetch[%0d]: got=%b stable=%b addr=%h instr=%h pc=%h p4=%h ret=%0d valid=%b fault=%b want addr/pc=%h instr=%h ret=%0d",
                 n, got, stable, a, instr, pc, pcPlus4, retired, instrValid, fault, m_pc, w, m_ret);
      end
      stall = int'($urandom_range(0, 3));
      ok = 1'b1;
      for (int i = 0; i < stall; i++) begin
        pcSrc = 1'b1; pcTarget = 32'h3;
        tick();
        if (imemReq !== 1'b0 || instrValid !== 1'b1 || pc !== m_pc) ok = 1'b0;
      end
      pcSrc = 1'b0;
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL rnd_stall[%0d]: req=%b valid=%b pc=%h want 0/1/%h", n, imemReq, instrValid, pc, m_pc); end
      src = ($urandom_range(0, 2) == 0);
      tgt = {$urandom_range(0, 255), 2'b00} | (($urandom_range(0, 9) == 0) ? 32'h2 : 32'h0);
      do_accept(src, tgt);
      if (m_fault) begin
        n_tests++;
        if (fault !== 1'b1 || imemReq !== 1'b0 || instrValid !== 1'b0 || retired !== m_ret) begin
          n_fail++; $display("FAIL rnd_fault[%0d]: fault=%b req=%b valid=%b ret=%0d want 1/0/0/%0d",
                             n, fault, imemReq, instrValid, retired, m_ret);
        end
        hard_reset();
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_hold_stall();
    test_branch();
    test_misaligned();
    test_reset_mid_fetch();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
